// File: rtl/ext_mem_loader.sv
// +--------------------------------------------------------------------------+
// | ext_mem_loader: host-side command engine for the CPU instruction/data    |
// | SRAM ext ports and the CPU enable; valid/ready command and response.     |
// | Optional: LOADER_READBACK_CHK_EN verifies every write by reading it back. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ext_mem_loader #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  input  logic [DATA_W-1:0] rdata_ext,
  output logic [ADDR_W-1:0] addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  input  logic [DATA_W-1:0] rdata_ext_2,
  output logic              cpu_enable,
  output logic              busy
);

  localparam logic [2:0] OP_WR_IMEM = 3'd0;
  localparam logic [2:0] OP_WR_DMEM = 3'd1;
  localparam logic [2:0] OP_RD_IMEM = 3'd2;
  localparam logic [2:0] OP_RD_DMEM = 3'd3;
  localparam logic [2:0] OP_RUN     = 3'd4;
  localparam logic [2:0] WAIT_LAST  = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_RWAIT = 3'd3,
    S_RUN   = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic              sel_dmem;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  run_len;
  logic [CNT_W-1:0]  run_cnt;
  logic [2:0]        wait_cnt;
  logic              port_act;
  logic [DATA_W-1:0] rdata_sel;
`ifdef LOADER_READBACK_CHK_EN
  logic              chk;
`endif

  // Ops 0..3 encode the target SRAM in bit 0: even = instruction, odd = data.
  assign rdata_sel = sel_dmem ? rdata_ext_2 : rdata_ext;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WR_IMEM, OP_WR_DMEM: state_nx = S_WRITE;
            OP_RD_IMEM, OP_RD_DMEM: state_nx = S_READ;
            OP_RUN:  state_nx = (cmd_data[CNT_W-1:0] == '0) ? S_RESP : S_RUN;
            default: state_nx = S_RESP;
          endcase
        end
      end
      S_WRITE: begin
`ifdef LOADER_READBACK_CHK_EN
        state_nx = S_READ;
`else
        state_nx = S_IDLE;
`endif
      end
      S_READ:  state_nx = S_RWAIT;
      S_RWAIT: begin
        if (wait_cnt == WAIT_LAST) begin
`ifdef LOADER_READBACK_CHK_EN
          if (chk && (rdata_sel == data_q)) state_nx = S_IDLE;
          else                               state_nx = S_RESP;
`else
          state_nx = S_RESP;
`endif
        end
      end
      S_RUN:   if (run_cnt == CNT_W'(1)) state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state    <= S_IDLE;
      sel_dmem <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      run_len  <= '0;
      run_cnt  <= '0;
      wait_cnt <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
`ifdef LOADER_READBACK_CHK_EN
      chk      <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            sel_dmem <= cmd_op[0];
            addr_q   <= cmd_addr;
            data_q   <= cmd_data;
            run_len  <= cmd_data[CNT_W-1:0];
            run_cnt  <= cmd_data[CNT_W-1:0];
            rsp_data <= '0;
            rsp_err  <= (cmd_op > OP_RUN);
          end
        end
        S_WRITE: begin
`ifdef LOADER_READBACK_CHK_EN
          chk <= 1'b1;
`endif
        end
        S_READ: wait_cnt <= '0;
        S_RWAIT: begin
          wait_cnt <= wait_cnt + 3'd1;
          if (wait_cnt == WAIT_LAST) begin
            rsp_data <= rdata_sel;
`ifdef LOADER_READBACK_CHK_EN
            rsp_err  <= chk && (rdata_sel != data_q);
            chk      <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          run_cnt <= run_cnt - CNT_W'(1);
          if (run_cnt == CNT_W'(1)) rsp_data <= DATA_W'(run_len);
        end
        S_RESP: if (rsp_ready) rsp_err <= 1'b0;
        default: ;
      endcase
    end
  end

  // Address is held on the selected port through WRITE/READ/RWAIT; idle ports drive zero.
  assign port_act    = (state == S_WRITE) || (state == S_READ) || (state == S_RWAIT);
  assign cmd_ready   = (state == S_IDLE);
  assign rsp_valid   = (state == S_RESP);
  assign busy        = (state != S_IDLE);
  assign cpu_enable  = (state == S_RUN);

  assign wen_ext     = (state == S_WRITE) && !sel_dmem;
  assign ren_ext     = (state == S_READ)  && !sel_dmem;
  assign addr_ext    = (port_act && !sel_dmem) ? addr_q : '0;
  assign wdata_ext   = wen_ext ? data_q : '0;

  assign wen_ext_2   = (state == S_WRITE) && sel_dmem;
  assign ren_ext_2   = (state == S_READ)  && sel_dmem;
  assign addr_ext_2  = (port_act && sel_dmem) ? addr_q : '0;
  assign wdata_ext_2 = wen_ext_2 ? data_q : '0;

endmodule

`default_nettype wire
